// File: rtl/s2_mailbox_pkg.sv
// Shared state encoding, mailbox word layout and write-back helper for the
// fabric-side mailbox responder.
package s2_mailbox_pkg;

    typedef enum logic [2:0] {IDLE, RD, RWAIT, EVAL, WR} state_e;

    localparam int VALID_BIT = 31;
    localparam int ACK_BIT   = 30;
    localparam int PAYLOAD_W = 8;

    // Write-back word: VALID cleared, ACK set, every other bit preserved.
    function automatic logic [31:0] mbox_ack(input logic [31:0] word);
        logic [31:0] w;
        w            = word;
        w[VALID_BIT] = 1'b0;
        w[ACK_BIT]   = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/s2_poll_timer.sv
// Reloadable poll-interval down-counter; expired is high while the count is 0.
module s2_poll_timer #(
    parameter int POLL_CYCLES = 1000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(POLL_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && !expired) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/s2_mailbox_responder.sv
// Polls the mailbox word over s2, latches posted payloads onto the LEDs and
// writes the word back acknowledged.
//
// state | meaning
// IDLE  | waiting for the poll timer (held while enable is low)
// RD    | read strobe to the mailbox word
// RWAIT | waiting out the read latency, samples readdata on the last cycle
// EVAL  | VALID set: latch payload and go write back; else back to IDLE
// WR    | write-back strobe with VALID cleared and ACK set
module s2_mailbox_responder
    import s2_mailbox_pkg::*;
#(
    parameter int                ADDR_W       = 10,
    parameter logic [ADDR_W-1:0] MBOX_ADDR    = 10'h3FF,
    parameter int                POLL_CYCLES  = 1000,
    parameter int                READ_LATENCY = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] s2_address,
    output logic              s2_chipselect,
    output logic              s2_clken,
    output logic              s2_write,
    input  logic [31:0]       s2_readdata,
    output logic [31:0]       s2_writedata,
    output logic [3:0]        s2_byteenable,
    output logic [7:0]        led_out,
    output logic              cmd_event,
    output logic              busy
);

    state_e                 state_q, state_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [PAYLOAD_W-1:0]   led_q, led_d;
    logic                   event_q, event_d;
    logic                   rw_cnt_q, rw_cnt_d;
    logic                   poll_expired;
    logic                   rd_sample;
    logic                   accept;

    s2_poll_timer #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_timer (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .load          (!(state_q == IDLE && enable)),
        .en            (state_q == IDLE && enable),
        .expired       (poll_expired)
    );

    // With a latency of 2 the first RWAIT cycle only arms rw_cnt_q.
    assign rd_sample = (state_q == RWAIT) && ((READ_LATENCY == 1) || rw_cnt_q);
    assign accept    = (state_q == EVAL) && rdata_q[VALID_BIT];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            led_q    <= '0;
            event_q  <= 1'b0;
            rw_cnt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            led_q    <= led_d;
            event_q  <= event_d;
            rw_cnt_q <= rw_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && poll_expired) state_d = RD;
            RD:      state_d = RWAIT;
            RWAIT:   if (rd_sample) state_d = EVAL;
            EVAL:    state_d = rdata_q[VALID_BIT] ? WR : IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = rd_sample ? s2_readdata : rdata_q;
        led_d    = accept ? rdata_q[PAYLOAD_W-1:0] : led_q;
        event_d  = accept;
        rw_cnt_d = (state_q == RWAIT);
    end

    always_comb begin
        s2_chipselect = 1'b0;
        s2_write      = 1'b0;
        s2_address    = '0;
        s2_byteenable = 4'h0;
        s2_writedata  = '0;
        case (state_q)
            RD: begin
                s2_chipselect = 1'b1;
                s2_address    = MBOX_ADDR;
                s2_byteenable = 4'hF;
            end
            WR: begin
                s2_chipselect = 1'b1;
                s2_write      = 1'b1;
                s2_address    = MBOX_ADDR;
                s2_byteenable = 4'hF;
                s2_writedata  = mbox_ack(rdata_q);
            end
            default: ;
        endcase
    end

    assign s2_clken  = s2_chipselect;
    assign busy      = (state_q != IDLE);
    assign led_out   = led_q;
    assign cmd_event = event_q;

endmodule

// File: tb/tb_s2_mailbox_responder.sv
// Scoreboard bench for the mailbox responder: two instances (POLL_CYCLES=4 /
// READ_LATENCY=1 and POLL_CYCLES=1 / READ_LATENCY=2) against a mailbox RAM model.
module tb_s2_mailbox_responder;

    localparam int P_A = 4, RL_A = 1, P_B = 1, RL_B = 2;
    localparam logic [9:0] MBOX = 10'h3FF;
    localparam int NEVER = 2147483647;

    typedef struct packed {
        int          cyc;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [9:0]  addr_a, addr_b;
    logic        cs_a, cs_b, ck_a, ck_b, wr_a, wr_b;
    logic [31:0] rdata_a, rdata_b, wdata_a, wdata_b;
    logic [3:0]  be_a, be_b;
    logic [7:0]  led_a, led_b;
    logic        ev_a, ev_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s2_mailbox_responder #(.ADDR_W(10), .MBOX_ADDR(MBOX), .POLL_CYCLES(P_A), .READ_LATENCY(RL_A)) u_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(en_a),
        .s2_address(addr_a), .s2_chipselect(cs_a), .s2_clken(ck_a), .s2_write(wr_a),
        .s2_readdata(rdata_a), .s2_writedata(wdata_a), .s2_byteenable(be_a),
        .led_out(led_a), .cmd_event(ev_a), .busy(busy_a));

    s2_mailbox_responder #(.ADDR_W(10), .MBOX_ADDR(MBOX), .POLL_CYCLES(P_B), .READ_LATENCY(RL_B)) u_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(en_b),
        .s2_address(addr_b), .s2_chipselect(cs_b), .s2_clken(ck_b), .s2_write(wr_b),
        .s2_readdata(rdata_b), .s2_writedata(wdata_b), .s2_byteenable(be_b),
        .led_out(led_b), .cmd_event(ev_b), .busy(busy_b));

    function automatic void chk(int inst, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d actual=%h required=%h", name, inst, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] ack_word(logic [31:0] w);
        return {1'b0, 1'b1, w[29:0]};
    endfunction

    // Mailbox RAM and reference model (owns mbox and the expectation queues' producer side)
    logic [31:0] mbox [2] = '{32'h0, 32'h0};
    logic [31:0] nwd  [2] = '{32'h0, 32'h0};
    int          nseq [2] = '{0, 0};
    int          nseen[2] = '{0, 0};
    exp_t        sb   [2][$];
    int          run  [2];
    int          idle_from [2];
    logic [2:0]  rd_v [2];
    logic [31:0] rd_d [2][3];

    always @(negedge clk) begin : model
        logic        c, w;
        logic [9:0]  ad;
        logic [31:0] wd, word;
        logic [3:0]  be;
        int          rl, p;
        for (int i = 0; i < 2; i++) begin
            c  = (i == 0) ? cs_a : cs_b;
            w  = (i == 0) ? wr_a : wr_b;
            ad = (i == 0) ? addr_a : addr_b;
            wd = (i == 0) ? wdata_a : wdata_b;
            be = (i == 0) ? be_a : be_b;
            rl = (i == 0) ? RL_A : RL_B;
            p  = (i == 0) ? P_A : P_B;
            if (nseq[i] != nseen[i]) begin
                mbox[i]  = nwd[i];
                nseen[i] = nseq[i];
            end
            if (!rst_n) begin
                sb[i].delete();
                run[i]       = 0;
                idle_from[i] = cyc + 1;
            end else if (c && !w) begin
                word = mbox[i];
                if (word[31]) begin
                    sb[i].push_back('{cyc + 2 + rl, 1'b1, ack_word(word)});
                    idle_from[i] = cyc + 3 + rl;
                end else begin
                    idle_from[i] = cyc + 2 + rl;
                end
                run[i] = 0;
            end else if (cyc >= idle_from[i]) begin
                run[i] = ((i == 0) ? en_a : en_b) ? run[i] + 1 : 0;
                if (run[i] == p) begin
                    sb[i].push_back('{cyc + 1, 1'b0, 32'h0});
                    idle_from[i] = NEVER;
                    run[i]       = 0;
                end
            end
            if (c && w && be == 4'hF && ad == MBOX) mbox[i] = wd;
            rd_v[i]    = {rd_v[i][1:0], rst_n && c && !w};
            rd_d[i][2] = rd_d[i][1];
            rd_d[i][1] = rd_d[i][0];
            rd_d[i][0] = mbox[i];
            word = rd_v[i][rl] ? rd_d[i][rl] : $urandom;
            if (i == 0) rdata_a = word; else rdata_b = word;
        end
    end

    // Monitor: pops one expectation per presented strobe
    logic [7:0] cur_led [2] = '{8'h0, 8'h0};
    int ev_cnt [2] = '{0, 0};
    int wr_cnt [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};

    always @(negedge clk) begin : monitor
        logic        s_cs, s_wr, s_ck, s_ev, s_busy, exp_ev;
        logic [9:0]  s_addr;
        logic [31:0] s_wd;
        logic [3:0]  s_be;
        logic [7:0]  s_led;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            s_cs   = (i == 0) ? cs_a : cs_b;
            s_wr   = (i == 0) ? wr_a : wr_b;
            s_ck   = (i == 0) ? ck_a : ck_b;
            s_ev   = (i == 0) ? ev_a : ev_b;
            s_busy = (i == 0) ? busy_a : busy_b;
            s_addr = (i == 0) ? addr_a : addr_b;
            s_wd   = (i == 0) ? wdata_a : wdata_b;
            s_be   = (i == 0) ? be_a : be_b;
            s_led  = (i == 0) ? led_a : led_b;
            exp_ev = 1'b0;
            if (!rst_n) begin
                cur_led[i] = 8'h0;
                chk(i, "rst_outputs", {s_cs, s_wr, s_ck, s_ev, s_busy, s_be, s_addr}, 32'h0);
                chk(i, "rst_led", s_led, 32'h0);
            end else begin
                if (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_missing inst%0d actual=none required=cycle %0d write=%0b",
                             i, sb[i][0].cyc, sb[i][0].wr);
                    void'(sb[i].pop_front());
                end
                if (s_cs) begin
                    checks++;
                    if (sb[i].size() == 0 || sb[i][0].cyc != cyc) begin
                        errors++;
                        $display("FAIL strobe_unexpected inst%0d actual=cycle %0d write=%0b required=none",
                                 i, cyc, s_wr);
                    end else begin
                        e = sb[i].pop_front();
                        chk(i, "strobe_write", s_wr, e.wr);
                        chk(i, "strobe_addr", s_addr, MBOX);
                        chk(i, "strobe_be", s_be, 4'hF);
                        if (e.wr) begin
                            chk(i, "writedata", s_wd, e.data);
                            cur_led[i] = e.data[7:0];
                            exp_ev     = 1'b1;
                        end
                    end
                end
                chk(i, "clken", s_ck, s_cs);
                chk(i, "cmd_event", s_ev, exp_ev);
                chk(i, "led_out", s_led, cur_led[i]);
                if (s_ev) ev_cnt[i]++;
                if (s_cs && s_wr) wr_cnt[i]++;
                if (s_cs && !s_wr) rd_cnt[i]++;
            end
        end
    end

    task automatic wait_strobe(input int i, input logic want_wr, input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (rst_n && ((i == 0) ? cs_a : cs_b) && (((i == 0) ? wr_a : wr_b) == want_wr)) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL timeout inst%0d actual=no %s required=%s within %0d cycles",
                     i, want_wr ? "write" : "read", want_wr ? "write" : "read", bound);
        end
    endtask

    task automatic post(input int i, input logic [31:0] w);
        @(posedge clk);
        #1;
        nwd[i] = w;
        nseq[i]++;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r, w, r2, e, posts[2], ev0[2], wr0[2], rd0;
        logic [31:0] cmd;
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "rst_async_a", {cs_a, ck_a, wr_a, ev_a, busy_a, led_a}, 32'h0);
        chk(1, "rst_async_b", {cs_b, ck_b, wr_b, ev_b, busy_b, led_b}, 32'h0);
        rst_n = 1'b1;
        e = cyc;
        wait_strobe(0, 1'b0, 20, r);
        chk(0, "first_read_after_reset", r - e, P_A);
        wait_strobe(0, 1'b0, 20, r2);
        chk(0, "idle_poll_period", r2 - r, P_A + 3);
        repeat (30) @(posedge clk);
        chk(0, "no_writes_idle_a", wr_cnt[0], 0);
        chk(1, "no_writes_idle_b", wr_cnt[1], 0);

        // Directed commands with latency checks
        post(0, 32'h8000_12A5);
        wait_strobe(0, 1'b0, 20, r);
        wait_strobe(0, 1'b1, 20, w);
        chk(0, "rd_to_wr_rl1", w - r, 3);
        wait_strobe(0, 1'b0, 20, r2);
        chk(0, "wr_to_next_rd", r2 - w, P_A + 1);
        chk(0, "mbox_after_ack", mbox[0], 32'h4000_12A5);
        chk(0, "led_a5", led_a, 8'hA5);

        post(1, 32'h8000_003C);
        wait_strobe(1, 1'b0, 20, r);
        wait_strobe(1, 1'b1, 20, w);
        chk(1, "rd_to_wr_rl2", w - r, 4);
        @(negedge clk);
        chk(1, "led_3c", led_b, 8'h3C);
        chk(1, "mbox_after_ack", mbox[1], 32'h4000_003C);

        // Randomized posting on both instances
        posts = '{0, 0};
        ev0   = ev_cnt;
        wr0   = wr_cnt;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!mbox[i][31] && (mbox[i][30] || mbox[i] == 32'h0) && $urandom_range(0, 1) == 1) begin
                    nwd[i] = {1'b1, 1'($urandom_range(0, 1)), 30'($urandom)};
                    nseq[i]++;
                    posts[i]++;
                end
            end
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        repeat (40) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i, "rand_accepted", ev_cnt[i] - ev0[i], posts[i]);
            chk(i, "rand_writes", wr_cnt[i] - wr0[i], posts[i]);
        end

        // Enable dropped in RWAIT: transaction finishes, then polling stops
        cmd = 32'h8123_4567;
        post(0, cmd);
        wait_strobe(0, 1'b0, 20, r);
        @(posedge clk);
        #1;
        en_a = 1'b0;
        wait_strobe(0, 1'b1, 10, w);
        chk(0, "en_drop_rd_to_wr", w - r, 3);
        chk(0, "en_drop_led", led_a, cmd[7:0]);
        rd0 = rd_cnt[0];
        repeat (30) @(posedge clk);
        chk(0, "no_reads_disabled", rd_cnt[0] - rd0, 0);
        #1;
        en_a = 1'b1;
        e    = cyc;
        wait_strobe(0, 1'b0, 20, r2);
        chk(0, "reenable_to_read", r2 - e, P_A);

        // Reset asserted during the write-back cycle
        cmd = 32'hC0AB_CD5A;
        post(0, cmd);
        wait_strobe(0, 1'b0, 20, r);
        repeat (3) @(posedge clk);
        #1;
        chk(0, "in_wr_cycle", {cs_a, wr_a}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk(0, "rst_in_wr_strobes", {cs_a, ck_a, wr_a, ev_a, busy_a}, 5'b0);
        chk(0, "rst_in_wr_led", led_a, 8'h0);
        @(negedge clk);
        chk(0, "ram_unchanged", mbox[0], cmd);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_strobe(0, 1'b1, 40, w);
        @(negedge clk);
        chk(0, "reaccept_after_reset", mbox[0], {2'b01, cmd[29:0]});
        chk(0, "reaccept_led", led_a, cmd[7:0]);

        // POLL_CYCLES=1: repost immediately after each acknowledge
        posts[1] = 0;
        ev0[1]   = ev_cnt[1];
        wr0[1]   = wr_cnt[1];
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!mbox[1][31] && mbox[1][30]) begin
                nwd[1] = {1'b1, 1'($urandom_range(0, 1)), 30'($urandom)};
                nseq[1]++;
                posts[1]++;
            end
        end
        repeat (20) @(posedge clk);
        chk(1, "repost_accepted_once", ev_cnt[1] - ev0[1], posts[1]);
        chk(1, "repost_events_eq_writes", wr_cnt[1] - wr0[1], ev_cnt[1] - ev0[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
